// File: rtl/matmul_apb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : matmul_apb_sequencer
//  Purpose  : APB master that runs one matrix-multiply job on the matmul
//             slave: load A/B rows, start, poll for completion, then read
//             every result element back and stream it out.
//  Revision : 1.0 - initial release
// ============================================================================
module matmul_apb_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int POLL_LIMIT = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    // job request
    input  logic                                 job_valid_i,
    output logic                                 job_ready_o,
    input  logic                                 job_mode_i,
    input  logic [1:0]                           job_dest_i,
    input  logic [1:0]                           job_c_i,
    input  logic [1:0]                           job_n_i,
    input  logic [1:0]                           job_k_i,
    input  logic [1:0]                           job_m_i,
    // operand buffer
    output logic                                 op_rd_o,
    output logic [$clog2(2*MAX_DIM)-1:0]         op_addr_o,
    input  logic [BUS_WIDTH-1:0]                 op_rdata_i,
    // APB master
    output logic                                 psel_o,
    output logic                                 penable_o,
    output logic                                 pwrite_o,
    output logic [ADDR_WIDTH-1:0]                paddr_o,
    output logic [BUS_WIDTH-1:0]                 pwdata_o,
    output logic [BUS_WIDTH/8-1:0]               pstrb_o,
    input  logic [BUS_WIDTH-1:0]                 prdata_i,
    input  logic                                 pready_i,
    input  logic                                 pslverr_i,
    // result stream
    output logic                                 res_valid_o,
    output logic [$clog2(MAX_DIM*MAX_DIM)-1:0]   res_idx_o,
    output logic [BUS_WIDTH-1:0]                 res_data_o,
    // status
    output logic                                 busy_o,
    output logic                                 job_done_o,
    output logic                                 job_err_o
);

    localparam int OP_AW  = $clog2(2*MAX_DIM);
    localparam int IDX_W  = $clog2(MAX_DIM*MAX_DIM);
    localparam int POLL_W = $clog2(POLL_LIMIT+1);
    localparam int IDXF_W = ADDR_WIDTH - 5;

    localparam logic [IDX_W-1:0]  ROW_LAST  = IDX_W'(MAX_DIM - 1);
    localparam logic [IDX_W-1:0]  ELEM_LAST = IDX_W'(MAX_DIM*MAX_DIM - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
    localparam logic [OP_AW-1:0]  B_BASE    = OP_AW'(MAX_DIM);

    localparam logic [4:0] REG_CTRL = 5'h00;
    localparam logic [4:0] REG_A    = 5'h04;
    localparam logic [4:0] REG_B    = 5'h08;
    localparam logic [4:0] REG_SCR  = 5'h10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_START  = 3'd3,
        S_POLL   = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    // Per-transfer phase; FETCH is only used in front of operand row writes.
    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_e;

    state_e                 state_q,     state_d;
    phase_e                 phase_q,     phase_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [POLL_W-1:0]      poll_q,      poll_d;
    logic                   err_q,       err_d;
    logic                   mode_q,      mode_d;
    logic [1:0]             dest_q,      dest_d;
    logic [1:0]             c_q,         c_d;
    logic [1:0]             n_q,         n_d;
    logic [1:0]             k_q,         k_d;
    logic [1:0]             m_q,         m_d;
    logic [BUS_WIDTH-1:0]   row_q,       row_d;
    logic                   res_valid_q, res_valid_d;
    logic [IDX_W-1:0]       res_idx_q,   res_idx_d;
    logic [BUS_WIDTH-1:0]   res_data_q,  res_data_d;

    logic                   w_xfer;
    logic                   w_load;
    logic                   w_complete;
    logic [4:0]             w_sel;
    logic [IDXF_W-1:0]      w_index;
    logic [BUS_WIDTH-1:0]   w_ctrl;

    // State, counters, latched job fields and the registered result stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_FETCH;
            idx_q       <= '0;
            poll_q      <= '0;
            err_q       <= 1'b0;
            mode_q      <= 1'b0;
            dest_q      <= '0;
            c_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            m_q         <= '0;
            row_q       <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
            dest_q      <= dest_d;
            c_q         <= c_d;
            n_q         <= n_d;
            k_q         <= k_d;
            m_q         <= m_d;
            row_q       <= row_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_data_q  <= res_data_d;
        end
    end

    // A transfer finishes when the slave answers in the ACCESS phase.
    always_comb begin
        w_complete = (phase_q == PH_ACCESS) && pready_i;
    end

    // Next-state logic for the job sequence and its per-transfer phases.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        poll_d      = poll_q;
        err_d       = err_q;
        mode_d      = mode_q;
        dest_d      = dest_q;
        c_d         = c_q;
        n_d         = n_q;
        k_d         = k_q;
        m_d         = m_q;
        row_d       = row_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        res_data_d  = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (job_valid_i) begin
                    mode_d  = job_mode_i;
                    dest_d  = job_dest_i;
                    c_d     = job_c_i;
                    n_d     = job_n_i;
                    k_d     = job_k_i;
                    m_d     = job_m_i;
                    idx_d   = '0;
                    poll_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD_A;
                    phase_d = PH_FETCH;
                end
            end

            S_LOAD_A, S_LOAD_B: begin
                case (phase_q)
                    PH_FETCH: phase_d = PH_SETUP;
                    PH_SETUP: begin
                        // Operand row is only valid now; hold it for ACCESS.
                        row_d   = op_rdata_i;
                        phase_d = PH_ACCESS;
                    end
                    default: begin
                        if (w_complete) begin
                            if (pslverr_i) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else if (idx_q == ROW_LAST) begin
                                idx_d = '0;
                                if (state_q == S_LOAD_A) begin
                                    state_d = S_LOAD_B;
                                    phase_d = PH_FETCH;
                                end else begin
                                    state_d = S_START;
                                    phase_d = PH_SETUP;
                                end
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                phase_d = PH_FETCH;
                            end
                        end
                    end
                endcase
            end

            S_START: begin
                if (phase_q != PH_ACCESS) begin
                    phase_d = PH_ACCESS;
                end else if (w_complete) begin
                    if (pslverr_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_POLL;
                        phase_d = PH_SETUP;
                    end
                end
            end

            S_POLL: begin
                if (phase_q != PH_ACCESS) begin
                    phase_d = PH_ACCESS;
                end else if (w_complete) begin
                    poll_d = poll_q + 1'b1;
                    if (pslverr_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (!prdata_i[0]) begin
                        idx_d   = '0;
                        state_d = S_READ;
                        phase_d = PH_SETUP;
                    end else if (poll_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        phase_d = PH_SETUP;
                    end
                end
            end

            S_READ: begin
                if (phase_q != PH_ACCESS) begin
                    phase_d = PH_ACCESS;
                end else if (w_complete) begin
                    if (pslverr_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        res_valid_d = 1'b1;
                        res_idx_d   = idx_q;
                        res_data_d  = prdata_i;
                        if (idx_q == ELEM_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            phase_d = PH_SETUP;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                phase_d = PH_FETCH;
            end

            default: begin
                state_d = S_IDLE;
                phase_d = PH_FETCH;
            end
        endcase
    end

    // Bus-facing decode: everything is a function of state so reset clears it at once.
    always_comb begin
        w_load    = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
        w_xfer    = (w_load || (state_q == S_START) || (state_q == S_POLL) ||
                     (state_q == S_READ)) && (phase_q != PH_FETCH);
        w_ctrl    = BUS_WIDTH'({m_q, k_q, n_q, 2'b00, c_q, dest_q, mode_q, 1'b1});
        w_sel     = REG_CTRL;
        w_index   = '0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        pwrite_o  = 1'b0;
        paddr_o   = '0;
        pwdata_o  = '0;
        pstrb_o   = '0;
        op_rd_o   = 1'b0;
        op_addr_o = '0;

        case (state_q)
            S_LOAD_A: begin
                w_sel   = REG_A;
                w_index = IDXF_W'(idx_q);
            end
            S_LOAD_B: begin
                w_sel   = REG_B;
                w_index = IDXF_W'(idx_q);
            end
            S_READ: begin
                w_sel   = REG_SCR + {1'b0, dest_q, 2'b00};
                w_index = IDXF_W'(idx_q);
            end
            default: begin
                w_sel   = REG_CTRL;
                w_index = '0;
            end
        endcase

        if (w_load && (phase_q == PH_FETCH)) begin
            op_rd_o   = 1'b1;
            op_addr_o = (state_q == S_LOAD_B) ? (B_BASE + OP_AW'(idx_q)) : OP_AW'(idx_q);
        end

        if (w_xfer) begin
            psel_o    = 1'b1;
            penable_o = (phase_q == PH_ACCESS);
            pwrite_o  = w_load || (state_q == S_START);
            paddr_o   = {w_index, w_sel};
            pstrb_o   = pwrite_o ? '1 : '0;
            if (w_load) begin
                pwdata_o = (phase_q == PH_SETUP) ? op_rdata_i : row_q;
            end else if (state_q == S_START) begin
                pwdata_o = w_ctrl;
            end
        end
    end

    // Status and result outputs.
    always_comb begin
        job_ready_o = (state_q == S_IDLE);
        busy_o      = (state_q != S_IDLE);
        job_done_o  = (state_q == S_DONE);
        job_err_o   = (state_q == S_DONE) && err_q;
        res_valid_o = res_valid_q;
        res_idx_o   = res_idx_q;
        res_data_o  = res_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_matmul_apb_sequencer
//  Purpose  : Self-checking bench: APB slave and operand buffer models, a
//             transaction-level expectation model and one compare process.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_apb_sequencer;

    localparam int MD  = 2;
    localparam int BW  = 32;
    localparam int AW  = 16;
    localparam int PL  = 64;
    localparam int OPW = $clog2(2*MD);
    localparam int RIW = $clog2(MD*MD);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           job_valid = 1'b0;
    logic           job_ready;
    logic           job_mode = 1'b0;
    logic [1:0]     job_dest = '0, job_c = '0, job_n = '0, job_k = '0, job_m = '0;
    logic           op_rd;
    logic [OPW-1:0] op_addr;
    logic [BW-1:0]  op_rdata = '0;
    logic           psel, penable, pwrite;
    logic [AW-1:0]  paddr;
    logic [BW-1:0]  pwdata;
    logic [BW/8-1:0] pstrb;
    logic [BW-1:0]  prdata = '0;
    logic           pready = 1'b0, pslverr = 1'b0;
    logic           res_valid;
    logic [RIW-1:0] res_idx;
    logic [BW-1:0]  res_data;
    logic           busy, job_done, job_err;

    matmul_apb_sequencer #(
        .DATA_WIDTH(16), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(MD), .POLL_LIMIT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_mode_i(job_mode),
        .job_dest_i(job_dest), .job_c_i(job_c), .job_n_i(job_n), .job_k_i(job_k), .job_m_i(job_m),
        .op_rd_o(op_rd), .op_addr_o(op_addr), .op_rdata_i(op_rdata),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
        .pslverr_i(pslverr), .res_valid_o(res_valid), .res_idx_o(res_idx),
        .res_data_o(res_data), .busy_o(busy), .job_done_o(job_done), .job_err_o(job_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic w; logic [AW-1:0] a; logic [BW-1:0] d; } xfer_t;
    typedef struct { logic [RIW-1:0] i; logic [BW-1:0] d; } res_t;

    int n_checks = 0;
    int n_fail   = 0;

    // test configuration (slave behaviour) and model state
    int          cfg_waits = 0, cfg_poll_busy = 0, cfg_err_at = -1;
    logic [31:0] seed = 32'h1234_5678;
    logic [BW-1:0] opmem [0:2*MD-1];
    xfer_t exp_x[$];
    res_t  exp_r[$];
    xfer_t seen[$];
    int    exp_lat = 0;
    logic  exp_err = 1'b0;
    logic  job_active = 1'b0;
    int    done_lat = 0, res_seen = 0;
    logic  done_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] scr_val(input logic [AW-1:0] a);
        return ({16'h0, a} * 32'h9E37_79B1) ^ seed;
    endfunction

    // Expected transfer list, results, latency and error for one job.
    function automatic void build(input logic mode, input logic [1:0] dest, c, n, k, m);
        xfer_t t;
        int polls;
        int last;
        exp_x.delete();
        exp_r.delete();
        for (int i = 0; i < MD; i++) begin
            t.w = 1'b1; t.a = AW'(i*32 + 4); t.d = opmem[i]; exp_x.push_back(t);
        end
        for (int i = 0; i < MD; i++) begin
            t.w = 1'b1; t.a = AW'(i*32 + 8); t.d = opmem[MD+i]; exp_x.push_back(t);
        end
        t.w = 1'b1; t.a = '0;
        t.d = BW'(1 + 2*int'(mode) + 4*int'(dest) + 16*int'(c) +
                  256*int'(n) + 1024*int'(k) + 4096*int'(m));
        exp_x.push_back(t);
        exp_err = (cfg_poll_busy >= PL);
        polls = exp_err ? PL : cfg_poll_busy + 1;
        for (int p = 0; p < polls; p++) begin
            t.w = 1'b0; t.a = '0; t.d = '0; exp_x.push_back(t);
        end
        if (!exp_err) begin
            for (int j = 0; j < MD*MD; j++) begin
                t.w = 1'b0; t.a = AW'(j*32 + 16 + 4*int'(dest)); t.d = '0; exp_x.push_back(t);
            end
        end
        if (cfg_err_at >= 0 && cfg_err_at < exp_x.size()) begin
            while (exp_x.size() > cfg_err_at + 1) void'(exp_x.pop_back());
            exp_err = 1'b1;
        end
        last = exp_x.size();
        exp_lat = 1;
        for (int q = 0; q < last; q++) begin
            exp_lat += 2 + cfg_waits;
            if (exp_x[q].w && (exp_x[q].a[4:0] == 5'h04 || exp_x[q].a[4:0] == 5'h08))
                exp_lat += 1;
            if (!exp_x[q].w && exp_x[q].a[4:0] >= 5'h10 && q != cfg_err_at) begin
                res_t r;
                r.i = RIW'(exp_x[q].a >> 5);
                r.d = scr_val(exp_x[q].a);
                exp_r.push_back(r);
            end
        end
    endfunction

    // Operand buffer: data for the address strobed in one cycle appears in the next.
    logic           ob_rd = 1'b0;
    logic [OPW-1:0] ob_a  = '0;
    always @(negedge clk) begin
        ob_rd = op_rd;
        ob_a  = op_addr;
    end
    always @(posedge clk) begin
        #1;
        op_rdata = ob_rd ? opmem[ob_a] : $urandom;
    end

    // APB slave: configurable wait states, poll busy count and one error slot.
    int s_wait = 0, s_xfer = 0, s_poll = 0;
    always @(posedge clk) begin
        #1;
        if (!busy) begin
            s_wait = 0; s_xfer = 0; s_poll = 0;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = $urandom;
        if (psel && penable) begin
            if (s_wait < cfg_waits) begin
                s_wait++;
            end else begin
                s_wait = 0;
                pready = 1'b1;
                if (s_xfer == cfg_err_at) pslverr = 1'b1;
                if (!pwrite) begin
                    if (paddr == '0) begin
                        prdata[0] = (s_poll < cfg_poll_busy);
                        s_poll++;
                    end else if (paddr[4:0] >= 5'h10) begin
                        prdata = scr_val(paddr);
                    end
                end
                s_xfer++;
            end
        end
    end

    // Single compare process: transfers, results, completion and idle behaviour.
    int   lat = 0, pen_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) lat++; else lat = 0;
            if (!busy) pen_cnt = 0;
            if (prev_done) check("job_ready after done", 64'(job_ready), 64'd1);
            if (job_active && !job_done) check("job_ready while busy", 64'(job_ready), 64'd0);
            if (!busy) check("psel idle", 64'(psel), 64'd0);
            if (psel && penable) pen_cnt++;
            if (psel && penable && pready) begin
                xfer_t s, e;
                s.w = pwrite; s.a = paddr; s.d = pwdata;
                seen.push_back(s);
                n_checks++;
                if (exp_x.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra transfer: got addr 0x%0h write %0d, expected none", paddr, pwrite);
                end else begin
                    e = exp_x.pop_front();
                    check("paddr", 64'(paddr), 64'(e.a));
                    check("pwrite", 64'(pwrite), 64'(e.w));
                    check("pwdata", 64'(pwdata), 64'(e.d));
                    check("pstrb", 64'(pstrb), e.w ? 64'hF : 64'h0);
                    check("penable cycles", 64'(pen_cnt), 64'(cfg_waits + 1));
                end
                pen_cnt = 0;
            end
            if (res_valid) begin
                res_t e;
                res_seen++;
                n_checks++;
                if (exp_r.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra result: got idx %0d data 0x%0h, expected none", res_idx, res_data);
                end else begin
                    e = exp_r.pop_front();
                    check("res_idx", 64'(res_idx), 64'(e.i));
                    check("res_data", 64'(res_data), 64'(e.d));
                end
            end
            if (job_done) begin
                check("job_done expected", 64'(job_active), 64'd1);
                check("job_err", 64'(job_err), 64'(exp_err));
                check("latency", 64'(lat), 64'(exp_lat));
                check("transfers left", 64'(exp_x.size()), 64'd0);
                check("results left", 64'(exp_r.size()), 64'd0);
                done_lat   = lat;
                done_err   = job_err;
                job_active = 1'b0;
            end
            prev_done = job_done;
        end else begin
            prev_done = 1'b0;
            lat = 0;
            pen_cnt = 0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " psel"},      64'(psel),      64'd0);
        check({tag, " penable"},   64'(penable),   64'd0);
        check({tag, " pwrite"},    64'(pwrite),    64'd0);
        check({tag, " paddr"},     64'(paddr),     64'd0);
        check({tag, " pwdata"},    64'(pwdata),    64'd0);
        check({tag, " pstrb"},     64'(pstrb),     64'd0);
        check({tag, " op_rd"},     64'(op_rd),     64'd0);
        check({tag, " op_addr"},   64'(op_addr),   64'd0);
        check({tag, " res_valid"}, 64'(res_valid), 64'd0);
        check({tag, " res_idx"},   64'(res_idx),   64'd0);
        check({tag, " res_data"},  64'(res_data),  64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " job_done"},  64'(job_done),  64'd0);
        check({tag, " job_err"},   64'(job_err),   64'd0);
        check({tag, " job_ready"}, 64'(job_ready), 64'd1);
    endtask

    task automatic recover();
        job_valid = 1'b0;
        rst_n = 1'b0;
        exp_x.delete();
        exp_r.delete();
        job_active = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_job(input logic mode, input logic [1:0] dest, c, n, k, m);
        int t;
        for (int i = 0; i < 2*MD; i++) opmem[i] = $urandom;
        seen.delete();
        res_seen = 0;
        build(mode, dest, c, n, k, m);
        t = 0;
        @(negedge clk);
        while (!job_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        job_valid = 1'b1;
        job_mode = mode; job_dest = dest; job_c = c; job_n = n; job_k = k; job_m = m;
        @(posedge clk);
        #1;
        job_active = 1'b1;
        // keep offering a different job while busy; it must not be taken
        job_mode = $urandom; job_dest = $urandom; job_c = $urandom;
        job_n = $urandom; job_k = $urandom; job_m = $urandom;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while (!job_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        job_valid = 1'b0;
        if (!job_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL job timeout: got no job_done, expected one within 3000 cycles");
            recover();
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_job(input logic mode, input logic [1:0] dest, c, n, k, m,
                           input int waits, input int pbusy, input int err_at);
        cfg_waits = waits; cfg_poll_busy = pbusy; cfg_err_at = err_at;
        seed = $urandom;
        start_job(mode, dest, c, n, k, m);
        wait_done();
    endtask

    initial begin
        int lit_addr [10];
        int cnt;
        logic seen_scr;
        lit_addr = '{'h04, 'h24, 'h08, 'h28, 'h00, 'h00, 'h14, 'h34, 'h54, 'h74};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed zero-wait job with hand-computed expectations.
        run_job(1'b1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 0, 0, -1);
        check("t1 transfer count", 64'(seen.size()), 64'd10);
        for (int i = 0; i < 10 && i < seen.size(); i++)
            check("t1 addr", 64'(seen[i].a), 64'(lit_addr[i]));
        if (seen.size() > 4) check("t1 control word", 64'(seen[4].d), 64'h2A07);
        check("t1 latency", 64'(done_lat), 64'd25);
        check("t1 err", 64'(done_err), 64'd0);
        check("t1 results", 64'(res_seen), 64'd4);

        // Two wait states on every transfer: 10 transfers x 2 extra cycles.
        run_job(1'b0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2, 0, -1);
        check("t2 latency", 64'(done_lat), 64'd45);

        // Three busy polls then clear.
        run_job(1'b1, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 0, 3, -1);
        cnt = 0;
        seen_scr = 1'b0;
        foreach (seen[i]) begin
            if (seen[i].a[4:0] >= 5'h10) seen_scr = 1'b1;
            if (!seen_scr && !seen[i].w && seen[i].a == '0) cnt++;
        end
        check("t3 polls before read", 64'(cnt), 64'd4);

        // Status never clears: poll limit reached.
        run_job(1'b0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 0, 1000, -1);
        cnt = 0;
        foreach (seen[i]) if (!seen[i].w && seen[i].a == '0) cnt++;
        check("t4 poll count", 64'(cnt), 64'd64);
        check("t4 err", 64'(done_err), 64'd1);
        check("t4 results", 64'(res_seen), 64'd0);

        // Slave error on the first B-row write (transfer index 2).
        run_job(1'b1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 0, 0, 2);
        cnt = 0;
        foreach (seen[i]) if (seen[i].w && seen[i].a == '0) cnt++;
        check("t5 control writes", 64'(cnt), 64'd0);
        check("t5 transfers", 64'(seen.size()), 64'd3);
        check("t5 err", 64'(done_err), 64'd1);

        // Reset while results are being read.
        cfg_waits = 1; cfg_poll_busy = 0; cfg_err_at = -1;
        seed = $urandom;
        start_job(1'b0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1);
        cnt = 0;
        while (!res_valid && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("t6 reached READ", 64'(res_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        job_valid = 1'b0;
        #1;
        check_reset_outputs("midjob reset");
        exp_x.delete();
        exp_r.delete();
        job_active = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal job after the reset.
        run_job(1'b1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 0, 0, -1);
        check("t7 latency", 64'(done_lat), 64'd25);
        check("t7 results", 64'(res_seen), 64'd4);

        // Randomized jobs.
        for (int r = 0; r < 12; r++) begin
            int ea;
            ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_job(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), ea);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
